ps2_note_receiver: RTL and testbench
====================================

PS2_NOTE_RECEIVER -- requirements
Module: ps2_note_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: Clock cycles without a clk_kb falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the clk_kb/data_kb synchronizers, minimum 2.
REQ-003 SHALL have port Clock, input, 1: the single system clock; all logic on posedge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port clk_kb, input, 1: PS/2 clock pin, asynchronous.
REQ-006 SHALL have port data_kb, input, 1: PS/2 data pin, asynchronous.
REQ-007 SHALL have port oScanCode, output, 8: make code of the currently held key; 8'h00 when no key is held.
REQ-008 SHALL have port oKeyHeld, output, 1: high while oScanCode holds a valid make code.
REQ-009 SHALL have port oScanValid, output, 1: one-cycle pulse when oScanCode changes to a new make code.
REQ-010 SHALL have port oFrameError, output, 1: one-cycle pulse on a start, parity or stop error, or on a timeout.

Function
REQ-011 SHALL pass clk_kb and data_kb through SYNC_STAGES flops each, then register the synchronized clk_kb once more to detect falling edges.
REQ-012 SHALL sample the synchronized data_kb only in the cycle a clk_kb falling edge is detected.
REQ-013 SHALL implement an FSM with states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: a sampled 0 (start bit) goes to DATA with bit count 0; a sampled 1 stays in IDLE with no error.
REQ-015 DATA: shifts 8 bits in LSB first; after the 8th bit goes to PARITY.
REQ-016 PARITY: captures the parity bit and goes to STOP.
REQ-017 STOP: the frame is good when the stop bit is 1 and parity is odd across data plus parity; the FSM returns to IDLE in all cases.
REQ-018 A bad frame SHALL pulse oFrameError and leave oScanCode, oKeyHeld and the break flag unchanged.
REQ-019 A good byte 8'hF0 SHALL set the break flag and change no output.
REQ-020 A good byte 8'hE0 SHALL be discarded with no output change.
REQ-021 A good byte with the break flag set:
- if the byte equals oScanCode: clears oScanCode to 8'h00 and oKeyHeld to 0;
- otherwise: no output change;
- in both cases: clears the break flag.
REQ-022 A good non-prefix byte with the break flag clear:
- if it differs from oScanCode: loads it into oScanCode, sets oKeyHeld and pulses oScanValid;
- if it equals oScanCode (typematic repeat): no pulse.
REQ-023 Outputs SHALL update in the cycle after the cycle in which the stop-bit falling edge is detected.
REQ-024 An idle counter SHALL clear on every falling edge and otherwise increment; in any state other than IDLE, reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE and pulses oFrameError.
REQ-025 The idle counter SHALL saturate and never wrap.
REQ-026 oScanValid and oFrameError SHALL never be high in the same cycle.

Reset
REQ-027 Reset SHALL force, on the next Clock edge:
- FSM to IDLE;
- bit count, idle counter and break flag to 0;
- oScanCode to 8'h00 and oKeyHeld to 0;
- oScanValid and oFrameError to 0;
- synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL discard the partial frame with no error pulse.

Configuration
REQ-029 With macro PS2_PARITY_CHECK_EN defined, a parity mismatch SHALL be a frame error.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled but ignored, and only the start and stop bits are checked.

Structure
REQ-031 The shared definitions package SHALL hold:
- prefix constants 8'hF0 and 8'hE0;
- FSM state encodings;
- note scan-code constants (DO, DOs, RE ... SI) already used by the display stage.
REQ-032 The synchronizer plus edge detector SHALL be one sub-module, ps2_sync_edge.

Verification
REQ-033 Frame 8'h1C, good parity -> oScanCode=8'h1C, oKeyHeld=1, and oScanValid high for exactly 1 cycle.
REQ-034 Frames 1C, F0, 1C -> oScanCode=8'h00 and oKeyHeld=0 after the third frame, with a single oScanValid pulse in total.
REQ-035 Frames 1C, F0, 1B -> oScanCode stays 8'h1C; a following 1C repeat gives no oScanValid pulse.
REQ-036 Frame 8'h23 with even parity -> oFrameError pulse and oScanCode unchanged with PS2_PARITY_CHECK_EN defined; oScanCode=8'h23 without it.
REQ-037 Start plus 4 data bits, then clk_kb held high for TIMEOUT_CYCLES -> one oFrameError pulse and FSM in IDLE; the next full frame 8'h1C is decoded correctly.
REQ-038 Reset asserted after the 5th bit of a frame -> all outputs at reset values, no oFrameError; the next frame decodes correctly.

Source files
------------

// File: rtl/ps2_note_receiver_pkg.sv
// Shared definitions for the PS/2 note receiver: prefix bytes, FSM states,
// note scan codes used by the display stage, and the frame parity helper.
package ps2_note_receiver_pkg;

  localparam logic [7:0] BREAK_CODE  = 8'hF0;
  localparam logic [7:0] EXTEND_CODE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  // Piano layout on the home row (white keys) and the row above (black keys)
  localparam logic [7:0] DO  = 8'h1C;
  localparam logic [7:0] DOs = 8'h1D;
  localparam logic [7:0] RE  = 8'h1B;
  localparam logic [7:0] REs = 8'h24;
  localparam logic [7:0] MI  = 8'h23;
  localparam logic [7:0] FA  = 8'h2B;
  localparam logic [7:0] FAs = 8'h2C;
  localparam logic [7:0] SO  = 8'h34;
  localparam logic [7:0] SOs = 8'h35;
  localparam logic [7:0] LA  = 8'h33;
  localparam logic [7:0] LAs = 8'h3C;
  localparam logic [7:0] SI  = 8'h3B;

  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

endpackage

// File: rtl/ps2_note_receiver_sync_edge.sv
// Brings the asynchronous PS/2 clock and data pins into the Clock domain and
// flags the cycle in which a falling edge of the keyboard clock is seen.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clk_kb,
  input  logic data_kb,
  output logic fallEdge,
  output logic dataSync
);

  logic [SYNC_STAGES-1:0] clkPipe;
  logic [SYNC_STAGES-1:0] dataPipe;
  logic                   clkPrev;

  // Flops reset high to match an idle bus, so leaving reset never fakes an edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clkPipe  <= '1;
      dataPipe <= '1;
      clkPrev  <= 1'b1;
    end else begin
      clkPipe  <= {clkPipe[SYNC_STAGES-2:0], clk_kb};
      dataPipe <= {dataPipe[SYNC_STAGES-2:0], data_kb};
      clkPrev  <= clkPipe[SYNC_STAGES-1];
    end
  end

  assign fallEdge = clkPrev & ~clkPipe[SYNC_STAGES-1];
  assign dataSync = dataPipe[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_note_receiver.sv
// PS/2 keyboard receiver that tracks the single held note key.
// Optional PS2_PARITY_CHECK_EN makes a parity mismatch a frame error.
import ps2_note_receiver_pkg::*;

module ps2_note_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clk_kb,
  input  logic       data_kb,
  output logic [7:0] oScanCode,
  output logic       oKeyHeld,
  output logic       oScanValid,
  output logic       oFrameError
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  localparam int             CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  IDLE_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic fallEdge;
  logic dataSync;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) syncEdge (
    .Clock    (Clock),
    .Reset    (Reset),
    .clk_kb   (clk_kb),
    .data_kb  (data_kb),
    .fallEdge (fallEdge),
    .dataSync (dataSync)
  );

  ps2State_t     state, stateNext;
  logic [2:0]    bitCount, bitCountNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          parityBit, parityNext;
  logic [CW-1:0] idleCount, idleNext;
  logic          breakFlag, breakNext;
  logic [7:0]    scanCode, codeNext;
  logic          keyHeld, heldNext;
  logic          scanValid, validNext;
  logic          frameError, errorNext;
  logic          frameGood;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      bitCount   <= 3'd0;
      shiftReg   <= 8'h00;
      parityBit  <= 1'b0;
      idleCount  <= '0;
      breakFlag  <= 1'b0;
      scanCode   <= 8'h00;
      keyHeld    <= 1'b0;
      scanValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCount   <= bitCountNext;
      shiftReg   <= shiftNext;
      parityBit  <= parityNext;
      idleCount  <= idleNext;
      breakFlag  <= breakNext;
      scanCode   <= codeNext;
      keyHeld    <= heldNext;
      scanValid  <= validNext;
      frameError <= errorNext;
    end
  end

  // Parity is always captured; it only gates acceptance when checking is built in
  assign frameGood = dataSync & (oddParityOk(shiftReg, parityBit) | ~PARITY_CHECK);

  always_comb begin
    stateNext    = state;
    bitCountNext = bitCount;
    shiftNext    = shiftReg;
    parityNext   = parityBit;
    breakNext    = breakFlag;
    codeNext     = scanCode;
    heldNext     = keyHeld;
    validNext    = 1'b0;
    errorNext    = 1'b0;

    if (fallEdge)
      idleNext = '0;
    else if (idleCount == IDLE_LIMIT)
      idleNext = idleCount;
    else
      idleNext = idleCount + 1'b1;

    // A stalled partial frame is abandoned before any bit on this edge is used
    if (state != IDLE && idleCount == IDLE_LIMIT) begin
      stateNext = IDLE;
      errorNext = 1'b1;
    end else if (fallEdge) begin
      case (state)
        IDLE: begin
          if (!dataSync) begin
            stateNext    = DATA;
            bitCountNext = 3'd0;
          end
        end
        DATA: begin
          shiftNext    = {dataSync, shiftReg[7:1]};
          bitCountNext = bitCount + 3'd1;
          if (bitCount == 3'd7)
            stateNext = PARITY;
        end
        PARITY: begin
          parityNext = dataSync;
          stateNext  = STOP;
        end
        STOP: begin
          stateNext = IDLE;
          if (!frameGood) begin
            errorNext = 1'b1;
          end else if (shiftReg == BREAK_CODE) begin
            breakNext = 1'b1;
          end else if (shiftReg == EXTEND_CODE) begin
            breakNext = breakFlag;
          end else if (breakFlag) begin
            breakNext = 1'b0;
            if (shiftReg == scanCode) begin
              codeNext = 8'h00;
              heldNext = 1'b0;
            end
          end else if (shiftReg != scanCode) begin
            codeNext  = shiftReg;
            heldNext  = 1'b1;
            validNext = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign oScanCode   = scanCode;
  assign oKeyHeld    = keyHeld;
  assign oScanValid  = scanValid;
  assign oFrameError = frameError;

endmodule

// File: tb/tb_ps2_note_receiver.sv
// Directed bench for ps2_note_receiver: drives PS/2 frames bit by bit and
// checks held code, pulse counts and error behaviour against hand-derived values.
module tb_ps2_note_receiver;

  localparam int TIMEOUT = 200;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       clk_kb;
  logic       data_kb;
  logic [7:0] oScanCode;
  logic       oKeyHeld;
  logic       oScanValid;
  logic       oFrameError;

  int compared    = 0;
  int mismatched  = 0;
  int validPulses = 0;
  int validCycles = 0;
  int errPulses   = 0;
  int bothHigh    = 0;
  int expValid    = 0;
  int expErr      = 0;
  logic validPrev = 1'b0;
  logic errPrev   = 1'b0;

  ps2_note_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .clk_kb      (clk_kb),
    .data_kb     (data_kb),
    .oScanCode   (oScanCode),
    .oKeyHeld    (oKeyHeld),
    .oScanValid  (oScanValid),
    .oFrameError (oFrameError)
  );

  always #5 Clock = ~Clock;

  // Pulse bookkeeping on the falling edge, away from the DUT's active edge
  always @(negedge Clock) begin
    if (oScanValid === 1'b1) validCycles++;
    if (oScanValid === 1'b1 && validPrev !== 1'b1) validPulses++;
    if (oFrameError === 1'b1 && errPrev !== 1'b1) errPulses++;
    if (oScanValid === 1'b1 && oFrameError === 1'b1) bothHigh++;
    validPrev = oScanValid;
    errPrev   = oFrameError;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic sendBits(input logic [10:0] bits, input int count);
    for (int i = 0; i < count; i++) begin
      data_kb = bits[i];
      waitCycles(5);
      clk_kb = 1'b0;
      waitCycles(10);
      clk_kb = 1'b1;
      waitCycles(5);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic badParity, input logic badStop);
    logic [10:0] bits;
    bits = {~badStop, (~^code) ^ badParity, code, 1'b0};
    sendBits(bits, 11);
    data_kb = 1'b1;
    waitCycles(5);
  endtask

  task automatic checkState(input string tag, input logic [7:0] code, input logic held);
    @(negedge Clock);
    checkOutput({tag, ".code"}, 32'(oScanCode), 32'(code));
    checkOutput({tag, ".held"}, 32'(oKeyHeld), 32'(held));
    checkOutput({tag, ".validPulses"}, 32'(validPulses), 32'(expValid));
    checkOutput({tag, ".errPulses"}, 32'(errPulses), 32'(expErr));
  endtask

  initial begin
    Reset   = 1'b1;
    clk_kb  = 1'b1;
    data_kb = 1'b1;
    waitCycles(4);
    @(negedge Clock);
    checkOutput("reset.code",  32'(oScanCode),   32'h00);
    checkOutput("reset.held",  32'(oKeyHeld),    32'h0);
    checkOutput("reset.valid", 32'(oScanValid),  32'h0);
    checkOutput("reset.error", 32'(oFrameError), 32'h0);
    Reset = 1'b0;
    waitCycles(4);

    // Press DO
    applyStimulus(8'h1C, 1'b0, 1'b0);
    expValid = 1;
    checkState("press1C", 8'h1C, 1'b1);

    // Release DO
    applyStimulus(8'hF0, 1'b0, 1'b0);
    checkState("breakPending", 8'h1C, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkState("release1C", 8'h00, 1'b0);

    // Release of a key that is not held, then a typematic repeat
    applyStimulus(8'h1C, 1'b0, 1'b0);
    expValid++;
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h1B, 1'b0, 1'b0);
    checkState("otherBreak", 8'h1C, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkState("repeat1C", 8'h1C, 1'b1);

    // Extended prefix is discarded
    applyStimulus(8'hE0, 1'b0, 1'b0);
    checkState("prefixE0", 8'h1C, 1'b1);

    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkState("release1Cb", 8'h00, 1'b0);

    // MI with even parity
    applyStimulus(8'h23, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    expErr++;
    checkState("badParity", 8'h00, 1'b0);
`else
    expValid++;
    checkState("badParity", 8'h23, 1'b1);
`endif
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h23, 1'b0, 1'b0);
    checkState("release23", 8'h00, 1'b0);

    // Stop bit low
    applyStimulus(8'h1B, 1'b0, 1'b1);
    expErr++;
    checkState("badStop", 8'h00, 1'b0);

    // Start plus four data bits of 1C, then the keyboard clock stalls
    sendBits(11'b000000_1100_0, 5);
    data_kb = 1'b1;
    waitCycles(TIMEOUT + 30);
    expErr++;
    checkState("timeout", 8'h00, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    expValid++;
    checkState("afterTimeout", 8'h1C, 1'b1);

    // Reset part-way through a frame
    sendBits(11'b000000_0001_0, 5);
    Reset = 1'b1;
    waitCycles(2);
    checkState("midReset", 8'h00, 1'b0);
    checkOutput("midReset.valid", 32'(oScanValid), 32'h0);
    checkOutput("midReset.error", 32'(oFrameError), 32'h0);
    Reset   = 1'b0;
    data_kb = 1'b1;
    waitCycles(3);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    expValid++;
    checkState("afterReset", 8'h1C, 1'b1);

    @(negedge Clock);
    checkOutput("validWidth", 32'(validCycles), 32'(expValid));
    checkOutput("exclusive", 32'(bothHigh), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
